// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: transmit sequencer states and byte width.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    ACK_WAIT = 2'd2,
    ACK_HOLD = 2'd3
  } tx_state_t;

  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_tx_sequencer_flex_counter.sv
// Generic up-counter with synchronous clear; wraps to zero after rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  // Next count: clear wins over enable; wrap back to zero after the rollover value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/i2c_tx_sequencer.sv
// Slave-side I2C transmit sequencer: shifts a byte out MSB-first on SCL falling
// edges, releases SDA for the 9th clock and reports the master's ACK/NACK.
module i2c_tx_sequencer
  import i2c_pkg::*;
#(
  parameter int BITS = BITS_PER_BYTE
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            scl_rising,
  input  logic            scl_falling,
  input  logic            start_found,
  input  logic            stop_found,
  input  logic            tx_enable,
  input  logic            sda_in,
  input  logic [BITS-1:0] tx_data,
  output logic            sda_out,
  output logic            data_request,
  output logic            byte_sent,
  output logic            master_ack,
  output logic            master_nack,
  output logic            busy
);

  localparam int CNT_W = $clog2(BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);

  tx_state_t       state_q, state_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic            sda_q, sda_d;
  logic            req_q, req_d;
  logic            sent_q, sent_d;
  logic            ack_q, ack_d;
  logic            nack_q, nack_d;
  logic            busy_q, busy_d;
  logic            load;
  logic [CNT_W-1:0] bit_cnt;

  // Coincident SCL edges are meaningless, so each edge only counts when alone.
  logic fall, rise, abort;
  assign fall  = scl_falling & ~scl_rising;
  assign rise  = scl_rising & ~scl_falling;
  assign abort = start_found | stop_found;

  flex_counter #(
    .NUM_CNT_BITS(CNT_W)
  ) u_bit_cnt (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (abort | load),
    .count_enable(fall & (state_q == SHIFT) & ~abort),
    .rollover_val(LAST_BIT),
    .count_out   (bit_cnt)
  );

  // Next-state, shift and pulse decode; bus conditions override every SCL edge.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    sda_d   = sda_q;
    req_d   = 1'b0;
    sent_d  = 1'b0;
    ack_d   = 1'b0;
    nack_d  = 1'b0;
    load    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      sda_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sda_d = 1'b1;
          if (fall && tx_enable) begin
            load    = 1'b1;
            shift_d = tx_data;
            sda_d   = tx_data[BITS-1];
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            if (bit_cnt == LAST_BIT) begin
              sda_d   = 1'b1;
              sent_d  = 1'b1;
              req_d   = 1'b1;
              state_d = ACK_WAIT;
            end else begin
              // Rotate rather than shift so every register bit stays in use.
              shift_d = {shift_q[BITS-2:0], shift_q[BITS-1]};
              sda_d   = shift_q[BITS-2];
            end
          end
        end
        ACK_WAIT: begin
          if (rise) begin
            if (sda_in) begin
              nack_d  = 1'b1;
              state_d = IDLE;
            end else begin
              ack_d   = 1'b1;
              state_d = ACK_HOLD;
            end
          end
        end
        ACK_HOLD: begin
          if (fall) begin
            load    = 1'b1;
            shift_d = tx_data;
            sda_d   = tx_data[BITS-1];
            state_d = SHIFT;
          end
        end
        default: begin
          state_d = IDLE;
          sda_d   = 1'b1;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset releases SDA immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      sda_q   <= 1'b1;
      req_q   <= 1'b0;
      sent_q  <= 1'b0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      sda_q   <= sda_d;
      req_q   <= req_d;
      sent_q  <= sent_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      busy_q  <= busy_d;
    end
  end

  assign sda_out      = sda_q;
  assign data_request = req_q;
  assign byte_sent    = sent_q;
  assign master_ack   = ack_q;
  assign master_nack  = nack_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_tx_sequencer.sv
// Self-checking bench for i2c_tx_sequencer: randomized byte transfers compared
// against a bit-order model of the I2C read frame.
module tb_i2c_tx_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       scl_rising, scl_falling, start_found, stop_found;
  logic       tx_enable, sda_in;
  logic [7:0] tx_data;
  logic       sda_out, data_request, byte_sent, master_ack, master_nack, busy;

  int vectors = 0;
  int miscompares = 0;
  int bs_total = 0, dr_total = 0, ack_total = 0, nack_total = 0;

  i2c_tx_sequencer #(.BITS(8)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .scl_rising  (scl_rising),
    .scl_falling (scl_falling),
    .start_found (start_found),
    .stop_found  (stop_found),
    .tx_enable   (tx_enable),
    .sda_in      (sda_in),
    .tx_data     (tx_data),
    .sda_out     (sda_out),
    .data_request(data_request),
    .byte_sent   (byte_sent),
    .master_ack  (master_ack),
    .master_nack (master_nack),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (byte_sent)    bs_total   <= bs_total + 1;
    if (data_request) dr_total   <= dr_total + 1;
    if (master_ack)   ack_total  <= ack_total + 1;
    if (master_nack)  nack_total <= nack_total + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: within a frame, the level after falling edge k is byte bit 7-k,
  // and the 9th falling edge releases SDA for the master's acknowledge.
  function automatic logic [8:0] model_frame_sda(input logic [7:0] b);
    logic [8:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    r[8] = 1'b1;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle input pulse; returns just after the capturing edge so outputs can be read.
  task automatic pulse(input logic f, input logic r, input logic st, input logic sp);
    scl_falling = f; scl_rising = r; start_found = st; stop_found = sp;
    @(posedge clk); #1;
    scl_falling = 1'b0; scl_rising = 1'b0; start_found = 1'b0; stop_found = 1'b0;
  endtask

  // Drives one 9-clock frame; the first falling edge is the load edge.
  task automatic send_frame(input logic [7:0] b, input logic ack_bit, input logic first,
                            output logic [8:0] sda_seq, output logic [8:0] bs_vec,
                            output logic [8:0] dr_vec, output logic got_ack,
                            output logic got_nack);
    got_ack = 1'b0;
    got_nack = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 0) begin
        tx_data   = b;
        tx_enable = first ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        tx_data   = 8'($urandom);
        tx_enable = (k < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      sda_seq[k] = sda_out;
      bs_vec[k]  = byte_sent;
      dr_vec[k]  = data_request;
      idle(1 + $urandom_range(0, 2));
      sda_in = (k == 8) ? ack_bit : 1'($urandom_range(0, 1));
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 8) begin
        got_ack  = master_ack;
        got_nack = master_nack;
      end
      idle(1 + $urandom_range(0, 2));
      sda_in = 1'b1;
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    scl_rising = 1'b0; scl_falling = 1'b0; start_found = 1'b0; stop_found = 1'b0;
    tx_enable = 1'b0; sda_in = 1'b1; tx_data = 8'h00;
    idle(3);
    n_rst = 1'b1;
    idle(2);
    vectors++;
    if (sda_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_sda: got %b expected 1", sda_out);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    vectors++;
    if ({byte_sent, data_request, master_ack, master_nack} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b expected 0000",
               {byte_sent, data_request, master_ack, master_nack});
    end
    $display("reset: sda_out=%b busy=%b", sda_out, busy);
  endtask

  task automatic test_single_ack;
    logic [8:0] seq, bsv, drv;
    logic ga, gn;
    send_frame(8'hA5, 1'b0, 1'b1, seq, bsv, drv, ga, gn);
    $display("single: byte=a5 sda_seq=%b ack=%b nack=%b", seq, ga, gn);
    vectors++;
    if (seq !== model_frame_sda(8'hA5)) begin
      miscompares++;
      $display("FAIL single_sda_seq: got %b expected %b", seq, model_frame_sda(8'hA5));
    end
    vectors++;
    if ({bsv, drv} !== {9'h100, 9'h100}) begin
      miscompares++;
      $display("FAIL single_pulses: byte_sent %b data_request %b expected 100000000 each", bsv, drv);
    end
    vectors++;
    if ({ga, gn} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_ack: got ack/nack %b expected 10", {ga, gn});
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_hold_busy: got %b expected 1", busy);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({busy, sda_out} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_start_idle: got busy/sda %b expected 01", {busy, sda_out});
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [7:0] byte_q[$];
    logic       ack_q[$];
    logic [8:0] seq, bsv, drv;
    logic       ga, gn, first;
    int         bs0, dr0, low_cnt;
    for (int t = 0; t < 4; t++) begin
      byte_q.delete();
      ack_q.delete();
      if (t == 0) begin
        byte_q.push_back(8'h3C); ack_q.push_back(1'b0);
        byte_q.push_back(8'hFF); ack_q.push_back(1'b1);
      end else begin
        int n = $urandom_range(2, 4);
        for (int i = 0; i < n; i++) begin
          byte_q.push_back(8'($urandom));
          ack_q.push_back(i == n - 1);
        end
      end
      first = 1'b1;
      bs0 = bs_total;
      dr0 = dr_total;
      for (int i = 0; i < byte_q.size(); i++) begin
        send_frame(byte_q[i], ack_q[i], first, seq, bsv, drv, ga, gn);
        first = 1'b0;
        $display("b2b: transfer=%0d byte=%h sda_seq=%b ack=%b nack=%b busy=%b",
                 t, byte_q[i], seq, ga, gn, busy);
        vectors++;
        if (seq !== model_frame_sda(byte_q[i])) begin
          miscompares++;
          $display("FAIL b2b_sda_seq: byte %h got %b expected %b", byte_q[i], seq,
                   model_frame_sda(byte_q[i]));
        end
        vectors++;
        if ({bsv, drv} !== {9'h100, 9'h100}) begin
          miscompares++;
          $display("FAIL b2b_pulses: byte_sent %b data_request %b expected 100000000 each", bsv, drv);
        end
        vectors++;
        if ({ga, gn} !== {~ack_q[i], ack_q[i]}) begin
          miscompares++;
          $display("FAIL b2b_ack: got ack/nack %b expected %b", {ga, gn}, {~ack_q[i], ack_q[i]});
        end
        vectors++;
        if (busy !== ~ack_q[i]) begin
          miscompares++;
          $display("FAIL b2b_busy: got %b expected %b", busy, ~ack_q[i]);
        end
      end
      vectors++;
      if ((bs_total - bs0) != byte_q.size() || (dr_total - dr0) != byte_q.size()) begin
        miscompares++;
        $display("FAIL b2b_request_count: got %0d/%0d expected %0d", bs_total - bs0,
                 dr_total - dr0, byte_q.size());
      end
      // After NACK the remaining clocks must leave the line released.
      low_cnt = 0;
      bs0 = bs_total;
      for (int i = 0; i < 3; i++) begin
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        if (sda_out !== 1'b1 || busy !== 1'b0) low_cnt++;
        idle(2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
      end
      vectors++;
      if (low_cnt != 0 || bs_total != bs0) begin
        miscompares++;
        $display("FAIL b2b_after_nack: got %0d active samples %0d pulses expected 0 0",
                 low_cnt, bs_total - bs0);
      end
    end
  endtask

  task automatic test_start_mid_byte;
    int bs0, bad;
    tx_data = 8'h00;
    tx_enable = 1'b1;
    bs0 = bs_total;
    for (int k = 0; k < 3; k++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      tx_enable = 1'b0;
      idle(2);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    vectors++;
    if (sda_out !== 1'b0) begin
      miscompares++;
      $display("FAIL start_mid_driving: got %b expected 0", sda_out);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    $display("start_mid: sda_out=%b busy=%b", sda_out, busy);
    vectors++;
    if ({sda_out, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL start_mid_release: got sda/busy %b expected 10", {sda_out, busy});
    end
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      if (sda_out !== 1'b1) bad++;
      idle(2);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    vectors++;
    if (bad != 0 || bs_total != bs0) begin
      miscompares++;
      $display("FAIL start_mid_quiet: got %0d low samples %0d byte_sent expected 0 0",
               bad, bs_total - bs0);
    end
  endtask

  task automatic test_reset_mid_byte;
    tx_data = 8'h00;
    tx_enable = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tx_enable = 1'b0;
    idle(1);
    vectors++;
    if (sda_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_driving: got %b expected 0", sda_out);
    end
    #2 n_rst = 1'b0;
    #1;
    $display("reset_mid: sda_out=%b busy=%b", sda_out, busy);
    vectors++;
    if ({sda_out, busy, byte_sent, data_request, master_ack, master_nack} !== 6'b100000) begin
      miscompares++;
      $display("FAIL rst_mid_async: got %b expected 100000",
               {sda_out, busy, byte_sent, data_request, master_ack, master_nack});
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    idle(1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({sda_out, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_mid_idle: got sda/busy %b expected 10", {sda_out, busy});
    end
    idle(2);
  endtask

  task automatic test_disabled;
    int bad, p0;
    tx_enable = 1'b0;
    bad = 0;
    p0 = bs_total + dr_total + ack_total + nack_total;
    for (int k = 0; k < 20; k++) begin
      tx_data = 8'($urandom);
      sda_in = 1'($urandom_range(0, 1));
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      if (sda_out !== 1'b1 || busy !== 1'b0) bad++;
      idle(1);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      if (sda_out !== 1'b1 || busy !== 1'b0) bad++;
      idle(1);
    end
    sda_in = 1'b1;
    $display("disabled: active samples=%0d pulses=%0d", bad,
             bs_total + dr_total + ack_total + nack_total - p0);
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL disabled_line: got %0d active samples expected 0", bad);
    end
    vectors++;
    if (bs_total + dr_total + ack_total + nack_total != p0) begin
      miscompares++;
      $display("FAIL disabled_pulses: got %0d expected 0",
               bs_total + dr_total + ack_total + nack_total - p0);
    end
  endtask

  task automatic test_stop_on_last;
    logic [7:0] b;
    int bs0;
    b = 8'($urandom) & 8'hFE;
    tx_data = b;
    tx_enable = 1'b1;
    bs0 = bs_total;
    for (int k = 0; k < 8; k++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      tx_enable = 1'b0;
      idle(2);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    $display("stop_last: byte=%h sda_out=%b busy=%b byte_sent=%b", b, sda_out, busy, byte_sent);
    vectors++;
    if ({sda_out, busy, byte_sent} !== 3'b100) begin
      miscompares++;
      $display("FAIL stop_last: got sda/busy/byte_sent %b expected 100",
               {sda_out, busy, byte_sent});
    end
    idle(2);
    vectors++;
    if (bs_total != bs0) begin
      miscompares++;
      $display("FAIL stop_last_count: got %0d byte_sent expected 0", bs_total - bs0);
    end
  endtask

  task automatic test_simultaneous_edges;
    logic [7:0] b;
    logic       held;
    b = 8'($urandom);
    tx_data = b;
    tx_enable = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tx_enable = 1'b0;
    idle(2);
    held = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      if (sda_out !== b[7]) held = 1'b0;
      idle(1);
    end
    vectors++;
    if (held !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_edges_hold: got sda %b expected %b", sda_out, b[7]);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    $display("simul: byte=%h sda_after_next_fall=%b", b, sda_out);
    vectors++;
    if (sda_out !== b[6]) begin
      miscompares++;
      $display("FAIL simul_edges_next: got %b expected %b", sda_out, b[6]);
    end
    idle(1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  initial begin
    test_reset();
    test_single_ack();
    test_back_to_back();
    test_start_mid_byte();
    test_reset_mid_byte();
    test_disabled();
    test_stop_on_last();
    test_simultaneous_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
